// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dual_issue_scheduler
//  Purpose  : In-order dual-issue scheduler with a per-register countdown
//             scoreboard (RAW/WAW tracking), even/odd pipe routing and a
//             saturating stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler #(
   parameter int NUM_REGS = 128,
   parameter int CNT_W    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid0,
   input  logic        in_valid1,
   input  logic        in_pipe0,
   input  logic        in_pipe1,
   input  logic [6:0]  in_rt0,
   input  logic [6:0]  in_rt1,
   input  logic        in_rtwr0,
   input  logic        in_rtwr1,
   input  logic [6:0]  in_ra0,
   input  logic [6:0]  in_rb0,
   input  logic [6:0]  in_rc0,
   input  logic [6:0]  in_ra1,
   input  logic [6:0]  in_rb1,
   input  logic [6:0]  in_rc1,
   input  logic [2:0]  in_use0,
   input  logic [2:0]  in_use1,
   input  logic [2:0]  in_lat0,
   input  logic [2:0]  in_lat1,
   input  logic        flush,
   input  logic        ds_ready,
   output logic        issue0,
   output logic        issue1,
   output logic        ep_issue,
   output logic        op_issue,
   output logic        ep_slot,
   output logic        op_slot,
   output logic [15:0] stall_cnt,
   output logic        sb_busy
);

   localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt [NUM_REGS];
   logic [CNT_W-1:0] w_cnt_nxt [NUM_REGS];
   logic             w_busy_nxt;
   logic [15:0]      r_stall;
   logic             r_busy;

   logic             w_rdy0, w_rdy1;
   logic             w_waw0, w_waw1;
   logic             w_pair_raw, w_pair_waw;
   logic             w_stall_inc;

   // Hazard evaluation and issue/route decisions for the current pair
   always_comb begin
      // A source is usable once its countdown is at most 1: forwarding covers the last cycle
      w_rdy0 = (~in_use0[2] | (r_cnt[in_ra0] <= c_ONE)) &
               (~in_use0[1] | (r_cnt[in_rb0] <= c_ONE)) &
               (~in_use0[0] | (r_cnt[in_rc0] <= c_ONE));
      w_rdy1 = (~in_use1[2] | (r_cnt[in_ra1] <= c_ONE)) &
               (~in_use1[1] | (r_cnt[in_rb1] <= c_ONE)) &
               (~in_use1[0] | (r_cnt[in_rc1] <= c_ONE));

      // A new writer must not complete before an older in-flight writer of the same register
      w_waw0 = in_rtwr0 & (r_cnt[in_rt0] > CNT_W'(in_lat0));
      w_waw1 = in_rtwr1 & (r_cnt[in_rt1] > CNT_W'(in_lat1));

      w_pair_raw = in_rtwr0 & ((in_use1[2] & (in_ra1 == in_rt0)) |
                               (in_use1[1] & (in_rb1 == in_rt0)) |
                               (in_use1[0] & (in_rc1 == in_rt0)));
      w_pair_waw = in_rtwr0 & in_rtwr1 & (in_rt1 == in_rt0);

      issue0 = ~reset & in_valid0 & ds_ready & ~flush & w_rdy0 & ~w_waw0;
      issue1 = issue0 & in_valid1 & (in_pipe1 != in_pipe0) & w_rdy1 & ~w_waw1 &
               ~w_pair_raw & ~w_pair_waw;

      // When both issue the pipes differ, so slot 1 owns whichever pipe it names
      ep_issue = (issue0 & ~in_pipe0) | (issue1 & ~in_pipe1);
      op_issue = (issue0 &  in_pipe0) | (issue1 &  in_pipe1);
      ep_slot  = issue1 & ~in_pipe1;
      op_slot  = issue1 &  in_pipe1;

      w_stall_inc = in_valid0 & ~flush & ~issue0;
   end

   // Next scoreboard state: decrement, with issued writes overriding the decrement
   always_comb begin
      w_busy_nxt = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_cnt_nxt[i] = (r_cnt[i] != '0) ? r_cnt[i] - c_ONE : '0;
         if (issue0 && in_rtwr0 && (in_rt0 == 7'(i)))
            w_cnt_nxt[i] = CNT_W'(in_lat0);
         if (issue1 && in_rtwr1 && (in_rt1 == 7'(i)))
            w_cnt_nxt[i] = CNT_W'(in_lat1);
         w_busy_nxt = w_busy_nxt | (w_cnt_nxt[i] != '0);
      end
   end

   // Scoreboard countdown registers; reset discards all in-flight state
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (reset)
            r_cnt[i] <= '0;
         else
            r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   // Saturating stall counter and registered busy flag
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall <= 16'd0;
         r_busy  <= 1'b0;
      end else begin
         if (w_stall_inc && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
         r_busy <= w_busy_nxt;
      end
   end

   assign stall_cnt = r_stall;
   assign sb_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dual_issue_scheduler
//  Purpose  : Directed-vector bench with expectation queue and monitor for
//             dual_issue_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid0, in_valid1, in_pipe0, in_pipe1;
   logic [6:0]  in_rt0, in_rt1, in_ra0, in_rb0, in_rc0, in_ra1, in_rb1, in_rc1;
   logic        in_rtwr0, in_rtwr1;
   logic [2:0]  in_use0, in_use1, in_lat0, in_lat1;
   logic        flush, ds_ready;
   logic        issue0, issue1, ep_issue, op_issue, ep_slot, op_slot;
   logic [15:0] stall_cnt;
   logic        sb_busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [5:0]  iss;   // {issue0,issue1,ep_issue,op_issue,ep_slot,op_slot}
      logic [15:0] st;
      logic        b;
      logic        chk;
      logic [6:0]  idx;
      logic [2:0]  cv;
   } exp_t;

   exp_t exp_q[$];

   dual_issue_scheduler #(.NUM_REGS(128), .CNT_W(3)) dut (
      .clock(clock), .reset(reset),
      .in_valid0(in_valid0), .in_valid1(in_valid1),
      .in_pipe0(in_pipe0), .in_pipe1(in_pipe1),
      .in_rt0(in_rt0), .in_rt1(in_rt1),
      .in_rtwr0(in_rtwr0), .in_rtwr1(in_rtwr1),
      .in_ra0(in_ra0), .in_rb0(in_rb0), .in_rc0(in_rc0),
      .in_ra1(in_ra1), .in_rb1(in_rb1), .in_rc1(in_rc1),
      .in_use0(in_use0), .in_use1(in_use1),
      .in_lat0(in_lat0), .in_lat1(in_lat1),
      .flush(flush), .ds_ready(ds_ready),
      .issue0(issue0), .issue1(issue1),
      .ep_issue(ep_issue), .op_issue(op_issue),
      .ep_slot(ep_slot), .op_slot(op_slot),
      .stall_cnt(stall_cnt), .sb_busy(sb_busy)
   );

   always #5 clock = ~clock;

   task automatic set0(input logic v, input logic p, input logic [6:0] rt, input logic wr,
                       input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                       input logic [2:0] u, input logic [2:0] lat);
      in_valid0 = v; in_pipe0 = p; in_rt0 = rt; in_rtwr0 = wr;
      in_ra0 = ra; in_rb0 = rb; in_rc0 = rc; in_use0 = u; in_lat0 = lat;
   endtask

   task automatic set1(input logic v, input logic p, input logic [6:0] rt, input logic wr,
                       input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                       input logic [2:0] u, input logic [2:0] lat);
      in_valid1 = v; in_pipe1 = p; in_rt1 = rt; in_rtwr1 = wr;
      in_ra1 = ra; in_rb1 = rb; in_rc1 = rc; in_use1 = u; in_lat1 = lat;
   endtask

   // Advance one cycle and return all controls to an idle default
   task automatic tick();
      @(posedge clock);
      #1;
      reset = 1'b0; flush = 1'b0; ds_ready = 1'b1;
      set0(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      set1(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
   endtask

   task automatic ex(input logic [5:0] iss, input logic [15:0] st, input logic b,
                     input logic chk, input logic [6:0] idx, input logic [2:0] cv);
      exp_t e;
      e.iss = iss; e.st = st; e.b = b; e.chk = chk; e.idx = idx; e.cv = cv;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are presented every cycle, consume one expectation per cycle
   initial begin
      exp_t e;
      logic [5:0] act;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {issue0, issue1, ep_issue, op_issue, ep_slot, op_slot};
            checks++;
            if (act !== e.iss || stall_cnt !== e.st || sb_busy !== e.b) begin
               failures++;
               $display("FAIL outputs t=%0t: iss/st/busy got %b/%0d/%b want %b/%0d/%b",
                        $time, act, stall_cnt, sb_busy, e.iss, e.st, e.b);
            end
            if (e.chk) begin
               checks++;
               if (dut.r_cnt[e.idx] !== e.cv) begin
                  failures++;
                  $display("FAIL cnt[%0d] t=%0t: got %0d want %0d",
                           e.idx, $time, dut.r_cnt[e.idx], e.cv);
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; ds_ready = 1'b1;
      set0(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      set1(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);

      // Reset held: issue forced low, registers cleared
      tick(); reset = 1'b1; set0(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b000000, 16'd0, 1'b0, 1'b0, 7'd0, 3'd0);
      tick(); ex(6'b000000, 16'd0, 1'b0, 1'b1, 7'd5, 3'd0);

      // Dual issue: even rt=5 lat=2, odd reads r7
      tick(); set0(1, 0, 5, 1, 0, 0, 0, 3'b000, 3'd2); set1(1, 1, 0, 0, 7, 0, 0, 3'b100, 3'd2);
      ex(6'b111101, 16'd0, 1'b0, 1'b0, 7'd0, 3'd0);
      tick(); ex(6'b000000, 16'd0, 1'b1, 1'b1, 7'd5, 3'd2);

      // Structural hazard: both even, slot 1 follows alone
      tick(); set0(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2); set1(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b101000, 16'd0, 1'b1, 1'b0, 7'd0, 3'd0);
      tick(); set0(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b101000, 16'd0, 1'b0, 1'b0, 7'd0, 3'd0);

      // RAW countdown: rt=10 lat=6 on odd pipe, reader arrives after one bubble
      tick(); set0(1, 1, 10, 1, 0, 0, 0, 3'b000, 3'd6);
      ex(6'b100100, 16'd0, 1'b0, 1'b0, 7'd0, 3'd0);
      tick(); ex(6'b000000, 16'd0, 1'b1, 1'b1, 7'd10, 3'd6);
      for (int k = 0; k < 4; k++) begin
         tick(); set0(1, 0, 0, 0, 10, 0, 0, 3'b100, 3'd2);
         ex(6'b000000, 16'(k), 1'b1, 1'b0, 7'd0, 3'd0);
      end
      tick(); set0(1, 0, 0, 0, 10, 0, 0, 3'b100, 3'd2);
      ex(6'b101000, 16'd4, 1'b1, 1'b1, 7'd10, 3'd1);

      // Intra-pair RAW: slot 1 reads slot 0's destination through rb
      tick(); set0(1, 0, 3, 1, 0, 0, 0, 3'b000, 3'd3); set1(1, 1, 0, 0, 0, 3, 0, 3'b010, 3'd2);
      ex(6'b101000, 16'd4, 1'b0, 1'b0, 7'd0, 3'd0);

      // WAW: rt=8 lat=7 then rt=8 lat=2 after one bubble
      tick(); set0(1, 1, 8, 1, 0, 0, 0, 3'b000, 3'd7);
      ex(6'b100100, 16'd4, 1'b1, 1'b0, 7'd0, 3'd0);
      tick(); ex(6'b000000, 16'd4, 1'b1, 1'b1, 7'd8, 3'd7);
      for (int k = 0; k < 4; k++) begin
         tick(); set0(1, 0, 8, 1, 0, 0, 0, 3'b000, 3'd2);
         ex(6'b000000, 16'(4 + k), 1'b1, 1'b0, 7'd0, 3'd0);
      end
      tick(); set0(1, 0, 8, 1, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b101000, 16'd8, 1'b1, 1'b1, 7'd8, 3'd2);

      // Flush with a valid pair: nothing issues, stall count held
      tick(); flush = 1'b1; set0(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2); set1(1, 1, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b000000, 16'd8, 1'b1, 1'b0, 7'd0, 3'd0);

      // Load cnt[8]=5, then reset mid-flight
      tick(); set0(1, 0, 8, 1, 0, 0, 0, 3'b000, 3'd5);
      ex(6'b101000, 16'd8, 1'b1, 1'b1, 7'd8, 3'd1);
      tick(); reset = 1'b1; set0(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b000000, 16'd8, 1'b1, 1'b1, 7'd8, 3'd5);
      tick(); set0(1, 0, 0, 0, 8, 0, 0, 3'b100, 3'd2);
      ex(6'b101000, 16'd0, 1'b0, 1'b1, 7'd8, 3'd0);

      // ds_ready low blocks issue and counts as a stall
      tick(); ds_ready = 1'b0; set0(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b000000, 16'd0, 1'b0, 1'b0, 7'd0, 3'd0);
      tick(); ex(6'b000000, 16'd1, 1'b0, 1'b0, 7'd0, 3'd0);

      // Intra-pair WAW: both write r20
      tick(); set0(1, 0, 20, 1, 0, 0, 0, 3'b000, 3'd2); set1(1, 1, 20, 1, 0, 0, 0, 3'b000, 3'd3);
      ex(6'b101000, 16'd1, 1'b0, 1'b0, 7'd0, 3'd0);

      // Reverse routing: slot 0 odd, slot 1 even
      tick(); set0(1, 1, 0, 0, 0, 0, 0, 3'b000, 3'd2); set1(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'd2);
      ex(6'b111110, 16'd1, 1'b1, 1'b1, 7'd20, 3'd2);

      // rc source at cnt=1 is ready
      tick(); set0(1, 0, 0, 0, 0, 0, 20, 3'b001, 3'd2);
      ex(6'b101000, 16'd1, 1'b1, 1'b1, 7'd20, 3'd1);
      tick(); ex(6'b000000, 16'd1, 1'b0, 1'b0, 7'd0, 3'd0);

      // Bounded drain of the expectation queue
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
      #1;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dual_issue_scheduler.md
DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_REGS, default 128, number of architectural registers tracked.
REQ-002 SHALL have parameter CNT_W, default 3, scoreboard countdown width; maximum pipeline latency 7.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid0/in_valid1  input  1 each  slot 0 (older) / slot 1 (younger) holds a decoded instruction.
REQ-006 SHALL have ports in_pipe0/in_pipe1  input  1 each  required pipe: 0 = even, 1 = odd.
REQ-007 SHALL have ports in_rt0/in_rt1  input  7 each  destination register; in_rtwr0/in_rtwr1  input  1 each  destination is written.
REQ-008 SHALL have ports in_ra/rb/rc 0 and 1  input  7 each  source registers; in_use0/in_use1  input  3 each  valid bits for {ra,rb,rc}.
REQ-009 SHALL have ports in_lat0/in_lat1  input  3 each  result latency in cycles, legal range 2..7.
REQ-010 SHALL have port flush  input  1  cancels the pending pair this cycle.
REQ-011 SHALL have port ds_ready  input  1  pipes can accept an issue this cycle.
REQ-012 SHALL have ports issue0/issue1  output  1 each  slot consumed this cycle (combinational).
REQ-013 SHALL have ports ep_issue/op_issue  output  1 each  even/odd pipe receives an instruction; ep_slot/op_slot  output  1 each  which slot drives that pipe.
REQ-014 SHALL have port stall_cnt  output  16  saturating count of stalled cycles (registered).
REQ-015 SHALL have port sb_busy  output  1  any scoreboard counter non-zero (registered).

Function
REQ-016 SHALL keep one CNT_W-bit countdown cnt[r] per register; every non-zero counter decrements by 1 each cycle.
REQ-017 SHALL treat source r as ready iff cnt[r] <= 1 (forwarding network supplies it next cycle).
REQ-018 SHALL flag WAW hazard for a slot iff rtwr set and cnt[rt] > that slot's lat.
REQ-019 SHALL assert issue0 iff in_valid0 & ds_ready & ~flush & all used sources of slot 0 ready & no WAW on slot 0.
REQ-020 SHALL assert issue1 iff issue0 & in_valid1 & in_pipe1 != in_pipe0 & slot-1 sources ready & no slot-1 WAW & no intra-pair RAW (slot-1 used source == in_rt0 with in_rtwr0) & no intra-pair WAW (both rtwr, in_rt1 == in_rt0).
REQ-021 SHALL never assert issue1 without issue0 (in-order issue); upstream holds unissued slots unchanged.
REQ-022 SHALL route an issued slot to the pipe named by its in_pipe; ep_slot/op_slot = 0 when the corresponding issue is low.
REQ-023 SHALL on clock edge load cnt[in_rtN] <= in_latN for each issued slot with rtwr; load overrides same-cycle decrement.
REQ-024 SHALL leave scoreboard unaffected by flush (in-flight older instructions complete normally).
REQ-025 SHALL increment stall_cnt when in_valid0 & ~flush & ~issue0; saturate at 16'hFFFF.
REQ-026 SHALL compute sb_busy from post-update counter values.
REQ-027 SHALL give ds_ready=0 priority: no issue, stall_cnt increments.

Reset
REQ-028 SHALL on reset clear all cnt[] to 0, stall_cnt to 0, sb_busy to 0; issue outputs forced 0 while reset high.
REQ-029 SHALL, if reset is asserted mid-operation, discard all pending scoreboard state in that edge; first post-reset cycle sees all registers ready.

Verification
REQ-030 SHALL verify dual issue: slot0 even rt=5 lat=2, slot1 odd ra=7, empty scoreboard -> issue0=issue1=1, ep_slot=0, op_slot=1, cnt[5]=2 next cycle.
REQ-031 SHALL verify structural hazard: both slots even pipe -> issue0=1, issue1=0; slot 1 issues alone next cycle as new slot 0.
REQ-032 SHALL verify RAW countdown: issue rt=10 lat=6, next instruction reads r10 -> stalls 4 cycles, issues when cnt[10]=1; stall_cnt=4.
REQ-033 SHALL verify intra-pair RAW: slot0 rt=3, slot1 rb=3 different pipes -> issue1=0.
REQ-034 SHALL verify WAW: issue rt=8 lat=7, then rt=8 lat=2 -> stalls until cnt[8] <= 2 (4 cycles).
REQ-035 SHALL verify flush/reset: flush with valid pair -> no issue, stall_cnt unchanged; reset with cnt[8]=5 -> cnt[8]=0, sb_busy=0 next cycle.
